// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one byte-addressed data memory between two requesters.
// Optional statistics counters are built when DMEM_ARB_STATS_EN is defined.
module dmem_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int MEM_BYTES = 1024,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_i,
    input  logic              we0_i,
    input  logic [1:0]        size0_i,
    input  logic [ADDR_W-1:0] addr0_i,
    input  logic [31:0]       wdata0_i,
    output logic              gnt0_o,
    output logic              rvalid0_o,
    output logic [31:0]       rdata0_o,
    output logic              err0_o,
    input  logic              req1_i,
    input  logic              we1_i,
    input  logic [1:0]        size1_i,
    input  logic [ADDR_W-1:0] addr1_i,
    input  logic [31:0]       wdata1_i,
    output logic              gnt1_o,
    output logic              rvalid1_o,
    output logic [31:0]       rdata1_o,
    output logic              err1_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    output logic              mem_read_o,
    output logic              mem_write_o,
    output logic [1:0]        mem_ltype_o,
    output logic [1:0]        mem_stype_o,
    input  logic [31:0]       mem_rdata_i,
    output logic [CNT_W-1:0]  cnt0_o,
    output logic [CNT_W-1:0]  cnt1_o,
    output logic [CNT_W-1:0]  err_cnt_o,
    output logic [1:0]        state_dbg
);

    // Handshake: a requester holds req and its fields stable until it sees gnt
    // (combinational, IDLE only); the matching rvalid pulse follows two cycles later.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W+1)'(MEM_BYTES);

    state_t            state, state_nx;
    logic              rr_ptr;
    logic              owner_r;
    logic              we_r;
    logic              err_r;
    logic [1:0]        size_r;
    logic [ADDR_W-1:0] addr_r;
    logic [31:0]       wdata_r;
    logic [31:0]       rdata_r;

    logic              any_req;
    logic              win;
    logic              sel_we;
    logic [1:0]        sel_size;
    logic [ADDR_W-1:0] sel_addr;
    logic [31:0]       sel_wdata;
    logic [3:0]        span;
    logic [ADDR_W:0]   end_addr;
    logic              req_err;

    assign state_dbg = state;
    assign any_req   = req0_i | req1_i;
    // Sole requester wins; on contention the round-robin pointer decides.
    assign win       = (req0_i & req1_i) ? rr_ptr : req1_i;
    assign sel_we    = win ? we1_i    : we0_i;
    assign sel_size  = win ? size1_i  : size0_i;
    assign sel_addr  = win ? addr1_i  : addr0_i;
    assign sel_wdata = win ? wdata1_i : wdata0_i;

    // End address is computed one bit wider so addresses near the top of the space cannot wrap.
    assign span     = 4'd1 << sel_size;
    assign end_addr = {1'b0, sel_addr} + {{(ADDR_W-3){1'b0}}, span};
    assign req_err  = (sel_size == 2'b11)
                    | ((sel_size == 2'b01) & sel_addr[0])
                    | ((sel_size == 2'b10) & (sel_addr[1:0] != 2'b00))
                    | (end_addr > MEM_LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (any_req) state_nx = ACCESS;
            ACCESS:  state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        gnt0_o      = 1'b0;
        gnt1_o      = 1'b0;
        rvalid0_o   = 1'b0;
        rvalid1_o   = 1'b0;
        rdata0_o    = 32'd0;
        rdata1_o    = 32'd0;
        err0_o      = 1'b0;
        err1_o      = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = 32'd0;
        mem_read_o  = 1'b0;
        mem_write_o = 1'b0;
        mem_ltype_o = 2'b00;
        mem_stype_o = 2'b00;
        case (state)
            IDLE: begin
                gnt0_o = rst_n & req0_i & ~win;
                gnt1_o = rst_n & req1_i & win;
            end
            ACCESS: begin
                mem_addr_o  = addr_r;
                mem_wdata_o = wdata_r;
                mem_read_o  = ~we_r & ~err_r;
                mem_write_o = we_r & ~err_r;
                mem_stype_o = we_r ? size_r : 2'b00;
                mem_ltype_o = we_r ? 2'b00 : size_r;
            end
            RESP: begin
                if (owner_r) begin
                    rvalid1_o = 1'b1;
                    rdata1_o  = rdata_r;
                    err1_o    = err_r;
                end else begin
                    rvalid0_o = 1'b1;
                    rdata0_o  = rdata_r;
                    err0_o    = err_r;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr  <= 1'b0;
            owner_r <= 1'b0;
            we_r    <= 1'b0;
            err_r   <= 1'b0;
            size_r  <= 2'b00;
            addr_r  <= '0;
            wdata_r <= 32'd0;
            rdata_r <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        owner_r <= win;
                        we_r    <= sel_we;
                        size_r  <= sel_size;
                        addr_r  <= sel_addr;
                        wdata_r <= sel_wdata;
                        err_r   <= req_err;
                    end
                end
                ACCESS:  rdata_r <= (!we_r && !err_r) ? mem_rdata_i : 32'd0;
                RESP:    rr_ptr  <= ~owner_r;
                default: ;
            endcase
        end
    end

`ifdef DMEM_ARB_STATS_EN
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt0_r, cnt1_r, err_cnt_r;

    // Counters saturate rather than wrap so a long run never reads as a short one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0_r    <= '0;
            cnt1_r    <= '0;
            err_cnt_r <= '0;
        end else if (state == RESP) begin
            if (!owner_r && cnt0_r != CNT_MAX) cnt0_r <= cnt0_r + CNT_ONE;
            if (owner_r && cnt1_r != CNT_MAX)  cnt1_r <= cnt1_r + CNT_ONE;
            if (err_r && err_cnt_r != CNT_MAX) err_cnt_r <= err_cnt_r + CNT_ONE;
        end
    end

    assign cnt0_o    = cnt0_r;
    assign cnt1_o    = cnt1_r;
    assign err_cnt_o = err_cnt_r;
`else
    assign cnt0_o    = '0;
    assign cnt1_o    = '0;
    assign err_cnt_o = '0;
`endif

endmodule
